ps_stream_fifo_writer: RTL and testbench
========================================

Name: ps_stream_fifo_writer

Overview:
Write-side front end for the pixel FIFOs that the processing-stage filters drain with rd/empty. It takes a camera or processing pixel stream, which has a valid strobe and no backpressure, and pushes it into a downstream FIFO through a wr/full handshake. A small skid buffer absorbs FIFO-full stalls; pixels that still cannot be stored are dropped and counted. At every start of frame it pulses a flush so downstream filter line buffers restart cleanly.

Parameters:
DW, 12, pixel width (RGB444 or greyscale in [11:4]).
DEPTH, 4, skid buffer entries; must be a power of 2, minimum 2.
CW, 16, width of the drop counter.

Ports:
i_clk  input  1  clock.
i_rst  input  1  synchronous, active-high reset.
i_enable  input  1  capture enable; low means incoming pixels are ignored.
i_sof  input  1  start-of-frame pulse, 1 cycle, may coincide with the first pixel's i_valid.
i_data  input  DW  pixel data.
i_valid  input  1  pixel strobe; no backpressure, the source never stalls.
i_full  input  1  downstream FIFO full.
o_wr  output  1  FIFO write strobe (combinational).
o_data  output  DW  FIFO write data, equal to the skid buffer head.
o_flush  output  1  1-cycle flush pulse to downstream blocks.
o_overflow  output  1  sticky flag: at least one pixel was dropped.
o_drop_count  output  CW  saturating count of dropped pixels.

Behaviour:
- Reset state: i_rst sampled high at an edge clears state to IDLE, buffer count to 0, rd/wr pointers to 0, o_flush=0, o_overflow=0, o_drop_count=0. o_wr is 0 because the buffer is empty. Reset mid-frame discards buffered pixels.
- State IDLE:
  - pixels are ignored and not counted as drops;
  - the buffer keeps draining.
  - IDLE->RUN on an edge where i_enable=1 and i_sof=1.
- State RUN:
  - each i_valid=1 pixel is pushed at the sampling edge.
  - RUN->IDLE on an edge where i_enable=0; the buffer still drains afterwards.
- SOF, in either state with i_enable=1:
  - o_flush is 1 for exactly the cycle after the sampling edge;
  - the buffer is emptied at that edge (pointers and count reset).
  - A pixel with i_valid=1 in the same cycle as i_sof is pushed into the emptied buffer as entry 0.
  - Back-to-back i_sof produces back-to-back flush cycles.
- Pop rule: o_wr = (count!=0) && !i_full && !o_flush. When o_wr=1 the head is popped at that edge.
- Latency: a pixel pushed at edge k has o_wr=1 in cycle k+1 if it is at the head and i_full=0.
  - Steady-state throughput is 1 pixel/cycle.
  - The first pixel after SOF appears one cycle later because of the flush cycle.
- Push rules:
  - Push is accepted if count<DEPTH, or if count==DEPTH and a pop occurs at the same edge (simultaneous push+pop at full is lossless).
  - Otherwise the pixel is dropped: o_overflow<=1, and o_drop_count increments, saturating at 2^CW-1.
  - Simultaneous push and pop leaves count unchanged.
- Ordering: pixels are written strictly in arrival order. Pointers wrap modulo DEPTH.
- o_overflow and o_drop_count are cleared only by i_rst; SOF does not clear them.
- i_full is used only combinationally, so no write ever occurs in a cycle where i_full=1.

Test Plan:
- Reset check: hold i_rst 2 cycles with i_valid toggling -> o_wr=0, o_flush=0, o_overflow=0, o_drop_count=0.
- Pixels before SOF: i_enable=1, 5 valid pixels with no i_sof -> o_wr never asserts, o_drop_count=0.
- Normal frame: i_sof together with pixels 0x001..0x004 on consecutive cycles, i_full=0 -> o_flush high in cycle 1 only; o_wr writes 0x001,0x002,0x003,0x004 in cycles 2..5.
- Overflow with DEPTH=4: after SOF, hold i_full=1 and send 6 pixels 0x010..0x015 -> 0x014 and 0x015 dropped, o_drop_count=2, o_overflow=1. Release i_full -> writes 0x010..0x013 on 4 consecutive cycles, then o_wr=0.
- Full-buffer edge cases:
  - Buffer full, i_full drops to 0 in the same cycle a new pixel 0x020 arrives -> pop and push both occur, no drop, 0x020 written last.
  - Saturation: force 2^CW+3 drops -> o_drop_count holds 0xFFFF.
- Mid-frame SOF and reset:
  - 3 pixels buffered with i_full=1, then i_sof with pixel 0x0AA -> o_flush pulses, old 3 pixels never written, only 0x0AA written after i_full clears.
  - Separately, i_rst mid-frame -> buffer empty and counters cleared the next cycle.

Source files
------------

// File: rtl/ps_stream_fifo_writer.sv
// Pixel-stream to FIFO write front end: skid buffer for FIFO-full stalls,
// counted drops on overflow, and a one-cycle flush pulse at every start of frame.
module ps_stream_fifo_writer #(
  parameter int DW    = 12,
  parameter int DEPTH = 4,
  parameter int CW    = 16
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_enable,
  input  logic          i_sof,
  input  logic [DW-1:0] i_data,
  input  logic          i_valid,
  input  logic          i_full,
  output logic          o_wr,
  output logic [DW-1:0] o_data,
  output logic          o_flush,
  output logic          o_overflow,
  output logic [CW-1:0] o_drop_count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

  typedef enum logic {IDLE, RUN} state_t;

  state_t        state_reg;
  logic [AW-1:0] rd_ptr_reg;
  logic [AW-1:0] wr_ptr_reg;
  logic [AW:0]   count_reg;
  logic          flush_reg;
  logic          overflow_reg;
  logic [CW-1:0] drop_count_reg;
  logic [DW-1:0] mem [DEPTH];

  logic          sof_take;
  logic          push_req;
  logic          pop;
  logic          push_ok;
  logic          drop;
  logic [AW-1:0] wr_idx;

  always_comb begin
    sof_take = i_enable && i_sof;
    // A SOF pixel is captured even from IDLE, since it opens the frame.
    push_req = i_valid && i_enable && ((state_reg == RUN) || i_sof);
    pop      = o_wr;
    push_ok  = push_req && (sof_take || (count_reg < FULL_COUNT) || pop);
    drop     = push_req && !push_ok;
    wr_idx   = sof_take ? '0 : wr_ptr_reg;
  end

  assign o_wr         = (count_reg != '0) && !i_full && !flush_reg;
  assign o_data       = mem[rd_ptr_reg];
  assign o_flush      = flush_reg;
  assign o_overflow   = overflow_reg;
  assign o_drop_count = drop_count_reg;

  always_ff @(posedge i_clk) begin
    if (push_ok) begin
      mem[wr_idx] <= i_data;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_reg      <= IDLE;
      rd_ptr_reg     <= '0;
      wr_ptr_reg     <= '0;
      count_reg      <= '0;
      flush_reg      <= 1'b0;
      overflow_reg   <= 1'b0;
      drop_count_reg <= '0;
    end else begin
      flush_reg <= sof_take;

      if (sof_take) begin
        state_reg <= RUN;
      end else if (!i_enable) begin
        state_reg <= IDLE;
      end

      // SOF discards whatever is buffered; the SOF pixel becomes entry 0.
      if (sof_take) begin
        rd_ptr_reg <= '0;
        wr_ptr_reg <= push_ok ? AW'(1) : '0;
        count_reg  <= push_ok ? (AW+1)'(1) : '0;
      end else begin
        if (pop) begin
          rd_ptr_reg <= rd_ptr_reg + AW'(1);
        end
        if (push_ok) begin
          wr_ptr_reg <= wr_ptr_reg + AW'(1);
        end
        case ({push_ok, pop})
          2'b10:   count_reg <= count_reg + (AW+1)'(1);
          2'b01:   count_reg <= count_reg - (AW+1)'(1);
          default: count_reg <= count_reg;
        endcase
      end

      if (drop) begin
        overflow_reg <= 1'b1;
        if (drop_count_reg != {CW{1'b1}}) begin
          drop_count_reg <= drop_count_reg + CW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_ps_stream_fifo_writer.sv
// Randomised and directed bench for ps_stream_fifo_writer against a queue-based model.
module tb_ps_stream_fifo_writer;

  localparam int DW    = 12;
  localparam int DEPTH = 4;
  localparam int CW    = 16;
  localparam int unsigned DROP_MAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          en = 1'b0;
  logic          sof = 1'b0;
  logic          valid = 1'b0;
  logic          full = 1'b0;
  logic [DW-1:0] data = '0;
  logic          wr;
  logic [DW-1:0] wdata;
  logic          flush;
  logic          overflow;
  logic [CW-1:0] drop_count;

  ps_stream_fifo_writer #(.DW(DW), .DEPTH(DEPTH), .CW(CW)) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_enable     (en),
    .i_sof        (sof),
    .i_data       (data),
    .i_valid      (valid),
    .i_full       (full),
    .o_wr         (wr),
    .o_data       (wdata),
    .o_flush      (flush),
    .o_overflow   (overflow),
    .o_drop_count (drop_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  bit verbose  = 1'b1;

  // Reference model: buffered pixels in arrival order plus frame/flush/drop state.
  logic [DW-1:0] q_m [$];
  bit            run_m   = 1'b0;
  bit            flush_m = 1'b0;
  bit            ovf_m   = 1'b0;
  int unsigned   drops_m = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step(input bit e, input bit s, input bit v, input logic [DW-1:0] d, input bit f);
    bit exp_wr;
    en = e; sof = s; valid = v; data = d; full = f;
    @(negedge clk);
    exp_wr = (q_m.size() != 0) && !f && !flush_m;
    check("wr", 32'(wr), 32'(exp_wr));
    if (exp_wr) check("data", 32'(wdata), 32'(q_m[0]));
    check("flush", 32'(flush), 32'(flush_m));
    check("overflow", 32'(overflow), 32'(ovf_m));
    check("drops", 32'(drop_count), drops_m);
    if (verbose && wr) $display("write data=%03h drops=%0d", wdata, drop_count);
    @(posedge clk);
    if (e && s) begin
      q_m.delete();
      if (v) q_m.push_back(d);
      flush_m = 1'b1;
      run_m   = 1'b1;
    end else begin
      flush_m = 1'b0;
      if (exp_wr) void'(q_m.pop_front());
      if (v && e && run_m) begin
        if (q_m.size() < DEPTH) q_m.push_back(d);
        else begin
          ovf_m = 1'b1;
          if (drops_m != DROP_MAX) drops_m++;
        end
      end
      if (!e) run_m = 1'b0;
    end
    #1;
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    for (int i = 0; i < n; i++) begin
      valid = ~valid;
      data  = DW'($urandom);
      @(posedge clk);
      #1;
    end
    rst = 1'b0; en = 1'b0; sof = 1'b0; valid = 1'b0; full = 1'b0;
    q_m.delete();
    run_m = 0; flush_m = 0; ovf_m = 0; drops_m = 0;
    @(negedge clk);
    check("rst_wr", 32'(wr), 32'd0);
    check("rst_flush", 32'(flush), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    check("rst_drops", 32'(drop_count), 32'd0);
    $display("reset released after %0d cycles", n);
    @(posedge clk);
    #1;
  endtask

  initial begin
    @(posedge clk);
    #1;
    do_reset(2);

    // Pixels without a SOF are ignored.
    for (int i = 0; i < 5; i++) step(1, 0, 1, DW'(i + 1), 0);
    step(1, 0, 0, 0, 0);
    check("pre_sof_drops", 32'(drop_count), 32'd0);

    // Normal frame.
    step(1, 1, 1, 12'h001, 0);
    step(1, 0, 1, 12'h002, 0);
    step(1, 0, 1, 12'h003, 0);
    step(1, 0, 1, 12'h004, 0);
    repeat (3) step(1, 0, 0, 0, 0);

    // Overflow with the FIFO held full.
    do_reset(1);
    step(1, 1, 0, 0, 1);
    for (int i = 0; i < 6; i++) step(1, 0, 1, DW'(12'h010 + i), 1);
    step(1, 0, 0, 0, 1);
    check("ovf_drops", 32'(drop_count), 32'd2);
    check("ovf_flag", 32'(overflow), 32'd1);
    repeat (6) step(1, 0, 0, 0, 0);

    // Full buffer, FIFO frees up as a new pixel arrives.
    for (int i = 0; i < 4; i++) step(1, 0, 1, DW'(12'h030 + i), 1);
    step(1, 0, 1, 12'h020, 0);
    check("simul_no_drop", 32'(drop_count), 32'd2);
    repeat (6) step(1, 0, 0, 0, 0);

    // Mid-frame SOF discards buffered pixels.
    for (int i = 0; i < 3; i++) step(1, 0, 1, DW'(12'h040 + i), 1);
    step(1, 1, 1, 12'h0AA, 1);
    step(1, 0, 0, 0, 1);
    repeat (4) step(1, 0, 0, 0, 0);

    // Back-to-back SOF.
    step(1, 1, 1, 12'h0B0, 0);
    step(1, 1, 1, 12'h0B1, 0);
    repeat (3) step(1, 0, 0, 0, 0);

    // Mid-frame reset.
    for (int i = 0; i < 3; i++) step(1, 0, 1, DW'(12'h050 + i), 1);
    do_reset(1);
    repeat (3) step(1, 0, 0, 0, 0);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 19) != 0), ($urandom_range(0, 39) == 0),
           ($urandom_range(0, 9) < 7), DW'($urandom), ($urandom_range(0, 9) < 3));
    end

    // Drop counter saturation.
    verbose = 1'b0;
    step(1, 1, 0, 0, 1);
    for (int i = 0; i < (1 << CW) + 3 + DEPTH; i++) step(1, 0, 1, DW'($urandom), 1);
    verbose = 1'b1;
    step(1, 0, 0, 0, 1);
    check("sat_drops", 32'(drop_count), 32'h0000FFFF);
    check("sat_flag", 32'(overflow), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
